// File: rtl/cpu24_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu24_pkg
// Brief   : Shared 24-bit CPU defaults and data-memory FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package cpu24_pkg;

    localparam int CPU_DATA_W = 24;
    localparam int CPU_ADDR_W = 8;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } mem_state_t;

    // A request that asserts both strobes at once is never serviced.
    function automatic logic op_conflict(input logic rd, input logic wr);
        return rd & wr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_responder_if
// Brief   : Load/store handshake between the datapath and the data memory.
// Revision: 1.0 - initial release
// ============================================================================
interface data_mem_responder_if
    import cpu24_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W
);
    logic              MemRead;
    logic              MemWrite;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData;
    logic              Ready;
    logic              Busy;
    logic              Error;

    modport master (
        output MemRead, MemWrite, Addr, WriteData,
        input  ReadData, Ready, Busy, Error
    );

    modport slave (
        input  MemRead, MemWrite, Addr, WriteData,
        output ReadData, Ready, Busy, Error
    );
endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module  : dmem_array
// Brief   : Single-port word array, synchronous write, registered read.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_array
    import cpu24_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DEPTH  = 256
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_responder
// Brief   : Multi-cycle data memory with programmable wait states and Ready.
// Revision: 1.0 - initial release
// ============================================================================
module data_mem_responder
    import cpu24_pkg::*;
#(
    parameter int DATA_W      = CPU_DATA_W,
    parameter int ADDR_W      = CPU_ADDR_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
)(
    input  logic                 Clock,
    input  logic                 Reset,
    data_mem_responder_if.slave  bus
);

    localparam logic [ADDR_W:0]     DEPTH_LIM = DEPTH[ADDR_W:0];
    localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CYCLES[WAIT_CNT_W-1:0];

    mem_state_t            state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [ADDR_W-1:0]     addr_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  op_rd;
    logic                  op_wr;
    logic                  ready_q;
    logic                  error_q;
    logic                  busy_q;
    logic [DATA_W-1:0]     rdata;
    logic                  access_ok;
    logic                  arr_we;
    logic                  arr_re;

    always_comb begin
        access_ok = (state == ST_ACCESS)
                  && !op_conflict(op_rd, op_wr)
                  && ({1'b0, addr_q} < DEPTH_LIM);
        arr_we    = access_ok & op_wr;
        arr_re    = access_ok & op_rd;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            op_rd    <= 1'b0;
            op_wr    <= 1'b0;
            ready_q  <= 1'b0;
            error_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.MemRead | bus.MemWrite) begin
                        addr_q  <= bus.Addr;
                        wdata_q <= bus.WriteData;
                        op_rd   <= bus.MemRead;
                        op_wr   <= bus.MemWrite;
                        busy_q  <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= ST_ACCESS;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == WAIT_CNT_W'(1)) begin
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    ready_q <= 1'b1;
                    error_q <= !access_ok;
                    state   <= ST_DONE;
                end
                ST_DONE: begin
                    // Return to IDLE regardless of the request level; the
                    // requester is dropping it during this cycle.
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (Clock),
        .rst   (Reset),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    assign bus.ReadData = rdata;
    assign bus.Ready    = ready_q;
    assign bus.Busy     = busy_q;
    assign bus.Error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_responder
// Brief   : Self-checking bench: two responders (DEPTH=200/WAIT=2, DEPTH=256/WAIT=0).
// Revision: 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int WC [2]    = '{2, 0};
    localparam int DEPTHS [2] = '{200, 256};

    logic Clock;
    logic Reset;
    int   cyc;
    int   n_checks;
    int   n_fail;

    logic        mr  [2];
    logic        mw  [2];
    logic [7:0]  ad  [2];
    logic [23:0] wdv [2];
    logic        rdy_w  [2];
    logic        busy_w [2];
    logic        err_w  [2];
    logic [23:0] rd_w   [2];

    // Reference model: word contents, written flags, last good read value
    logic [23:0] mmem [2][256];
    bit          mval [2][256];
    logic [23:0] mrd  [2];

    data_mem_responder_if #(.DATA_W(24), .ADDR_W(8)) bus0 ();
    data_mem_responder_if #(.DATA_W(24), .ADDR_W(8)) bus1 ();

    data_mem_responder #(.DATA_W(24), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(2)) dut0 (
        .Clock (Clock), .Reset (Reset), .bus (bus0)
    );
    data_mem_responder #(.DATA_W(24), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut1 (
        .Clock (Clock), .Reset (Reset), .bus (bus1)
    );

    assign bus0.MemRead = mr[0];  assign bus0.MemWrite = mw[0];
    assign bus0.Addr    = ad[0];  assign bus0.WriteData = wdv[0];
    assign bus1.MemRead = mr[1];  assign bus1.MemWrite = mw[1];
    assign bus1.Addr    = ad[1];  assign bus1.WriteData = wdv[1];
    assign rdy_w[0] = bus0.Ready; assign busy_w[0] = bus0.Busy;
    assign err_w[0] = bus0.Error; assign rd_w[0]   = bus0.ReadData;
    assign rdy_w[1] = bus1.Ready; assign busy_w[1] = bus1.Busy;
    assign err_w[1] = bus1.Error; assign rd_w[1]   = bus1.ReadData;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    initial cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic model_txn(input int d, input logic rd, input logic wr, input logic [7:0] a,
                             input logic [23:0] wdat, output logic exp_e, output logic [23:0] exp_rd);
        exp_e = (rd && wr) || (int'(a) >= DEPTHS[d]);
        if (!exp_e) begin
            if (wr) begin
                mmem[d][a] = wdat;
                mval[d][a] = 1'b1;
            end else begin
                mrd[d] = mmem[d][a];
            end
        end
        exp_rd = mrd[d];
    endtask

    // Drives one request and observes it; hold keeps the request up through DONE
    task automatic run_txn(input int d, input logic rd, input logic wr, input logic [7:0] a,
                           input logic [23:0] wdat, input bit hold, output int lat,
                           output logic e, output logic [23:0] data, output bit busy_ok,
                           output int start_cyc);
        @(posedge Clock); #1;
        mr[d] = rd; mw[d] = wr; ad[d] = a; wdv[d] = wdat;
        start_cyc = cyc;
        busy_ok = (busy_w[d] === 1'b0);
        lat = -1; e = 1'bx; data = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(posedge Clock); #1;
            if (busy_w[d] !== 1'b1) busy_ok = 1'b0;
            if (rdy_w[d] === 1'b1) begin
                lat = k; e = err_w[d]; data = rd_w[d];
                break;
            end
        end
        if (hold) begin
            @(posedge Clock); #1;
        end
        mr[d] = 1'b0; mw[d] = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (rdy_w[d] !== 1'b0 || busy_w[d] !== 1'b0 || err_w[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ctrl dut%0d: got ready=%b busy=%b error=%b, want 0 0 0",
                         d, rdy_w[d], busy_w[d], err_w[d]);
            end
            n_checks++;
            if (rd_w[d] !== 24'h0) begin
                n_fail++;
                $display("FAIL reset_rdata dut%0d: got %h want 000000", d, rd_w[d]);
            end
        end
        Reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat, sc; logic e, ee; logic [23:0] dat, erd; bit bok;
        model_txn(0, 1'b0, 1'b1, 8'h10, 24'hABCDEF, ee, erd);
        run_txn(0, 1'b0, 1'b1, 8'h10, 24'hABCDEF, 1'b0, lat, e, dat, bok, sc);
        n_checks++;
        if (lat !== 4 || e !== 1'b0 || !bok) begin
            n_fail++;
            $display("FAIL basic_write: got lat=%0d err=%b busy_ok=%b, want lat=4 err=0 busy_ok=1", lat, e, bok);
        end
        model_txn(0, 1'b1, 1'b0, 8'h10, 24'h0, ee, erd);
        run_txn(0, 1'b1, 1'b0, 8'h10, 24'h0, 1'b0, lat, e, dat, bok, sc);
        n_checks++;
        if (lat !== 4 || e !== 1'b0 || dat !== 24'hABCDEF) begin
            n_fail++;
            $display("FAIL basic_read: got lat=%0d err=%b data=%h, want lat=4 err=0 data=abcdef", lat, e, dat);
        end
    endtask

    task automatic test_zero_wait();
        int lat, sc, prev; logic e, ee; logic [23:0] dat, erd; bit bok;
        model_txn(1, 1'b0, 1'b1, 8'h00, 24'h000001, ee, erd);
        run_txn(1, 1'b0, 1'b1, 8'h00, 24'h000001, 1'b0, lat, e, dat, bok, sc);
        prev = sc;
        model_txn(1, 1'b1, 1'b0, 8'h00, 24'h0, ee, erd);
        run_txn(1, 1'b1, 1'b0, 8'h00, 24'h0, 1'b0, lat, e, dat, bok, sc);
        n_checks++;
        if (lat !== 2 || e !== 1'b0 || dat !== 24'h000001 || !bok) begin
            n_fail++;
            $display("FAIL zw_read: got lat=%0d err=%b data=%h busy_ok=%b, want 2 0 000001 1", lat, e, dat, bok);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (sc - prev !== 3) begin
                n_fail++;
                $display("FAIL zw_spacing%0d: got %0d cycles want 3", i, sc - prev);
            end
            prev = sc;
            model_txn(1, 1'b1, 1'b0, 8'h00, 24'h0, ee, erd);
            run_txn(1, 1'b1, 1'b0, 8'h00, 24'h0, 1'b0, lat, e, dat, bok, sc);
        end
    endtask

    task automatic test_error_both();
        int lat, sc; logic e, ee; logic [23:0] dat, erd; bit bok;
        model_txn(0, 1'b0, 1'b1, 8'h20, 24'h555555, ee, erd);
        run_txn(0, 1'b0, 1'b1, 8'h20, 24'h555555, 1'b0, lat, e, dat, bok, sc);
        model_txn(0, 1'b1, 1'b0, 8'h10, 24'h0, ee, erd);
        run_txn(0, 1'b1, 1'b0, 8'h10, 24'h0, 1'b0, lat, e, dat, bok, sc);
        model_txn(0, 1'b1, 1'b1, 8'h20, 24'h0F0F0F, ee, erd);
        run_txn(0, 1'b1, 1'b1, 8'h20, 24'h0F0F0F, 1'b0, lat, e, dat, bok, sc);
        n_checks++;
        if (lat !== 4 || e !== 1'b1 || dat !== 24'hABCDEF) begin
            n_fail++;
            $display("FAIL both_err: got lat=%0d err=%b data=%h, want 4 1 abcdef", lat, e, dat);
        end
        model_txn(0, 1'b1, 1'b0, 8'h20, 24'h0, ee, erd);
        run_txn(0, 1'b1, 1'b0, 8'h20, 24'h0, 1'b0, lat, e, dat, bok, sc);
        n_checks++;
        if (e !== 1'b0 || dat !== 24'h555555) begin
            n_fail++;
            $display("FAIL both_after: got err=%b data=%h, want 0 555555", e, dat);
        end
    endtask

    task automatic test_depth();
        int lat, sc; logic e, ee; logic [23:0] dat, erd; bit bok;
        model_txn(0, 1'b1, 1'b0, 8'hC8, 24'h0, ee, erd);
        run_txn(0, 1'b1, 1'b0, 8'hC8, 24'h0, 1'b0, lat, e, dat, bok, sc);
        n_checks++;
        if (lat !== 4 || e !== 1'b1 || dat !== 24'h555555) begin
            n_fail++;
            $display("FAIL depth_rd_c8: got lat=%0d err=%b data=%h, want 4 1 555555", lat, e, dat);
        end
        model_txn(0, 1'b0, 1'b1, 8'hC8, 24'h999999, ee, erd);
        run_txn(0, 1'b0, 1'b1, 8'hC8, 24'h999999, 1'b0, lat, e, dat, bok, sc);
        n_checks++;
        if (e !== 1'b1) begin
            n_fail++;
            $display("FAIL depth_wr_c8: got err=%b want 1", e);
        end
        model_txn(0, 1'b0, 1'b1, 8'hC7, 24'h7E7E7E, ee, erd);
        run_txn(0, 1'b0, 1'b1, 8'hC7, 24'h7E7E7E, 1'b0, lat, e, dat, bok, sc);
        model_txn(0, 1'b1, 1'b0, 8'hC7, 24'h0, ee, erd);
        run_txn(0, 1'b1, 1'b0, 8'hC7, 24'h0, 1'b0, lat, e, dat, bok, sc);
        n_checks++;
        if (e !== 1'b0 || dat !== 24'h7E7E7E) begin
            n_fail++;
            $display("FAIL depth_c7: got err=%b data=%h, want 0 7e7e7e", e, dat);
        end
    endtask

    task automatic test_reset_abort();
        int lat, sc, nrdy; logic e, ee; logic [23:0] dat, erd; bit bok;
        model_txn(0, 1'b0, 1'b1, 8'h05, 24'h111111, ee, erd);
        run_txn(0, 1'b0, 1'b1, 8'h05, 24'h111111, 1'b0, lat, e, dat, bok, sc);
        @(posedge Clock); #1;
        mw[0] = 1'b1; ad[0] = 8'h05; wdv[0] = 24'h123456;
        @(posedge Clock); #1;
        nrdy = (rdy_w[0] === 1'b1) ? 1 : 0;
        Reset = 1'b1; mw[0] = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b0;
        mrd[0] = 24'h0; mrd[1] = 24'h0;
        n_checks++;
        if (rdy_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || err_w[0] !== 1'b0 || rd_w[0] !== 24'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: got ready=%b busy=%b error=%b rdata=%h, want 0 0 0 000000",
                     rdy_w[0], busy_w[0], err_w[0], rd_w[0]);
        end
        for (int k = 0; k < 6; k++) begin
            @(posedge Clock); #1;
            if (rdy_w[0] === 1'b1) nrdy++;
        end
        n_checks++;
        if (nrdy !== 0) begin
            n_fail++;
            $display("FAIL abort_noready: got %0d Ready pulses want 0", nrdy);
        end
        model_txn(0, 1'b1, 1'b0, 8'h05, 24'h0, ee, erd);
        run_txn(0, 1'b1, 1'b0, 8'h05, 24'h0, 1'b0, lat, e, dat, bok, sc);
        n_checks++;
        if (e !== 1'b0 || dat !== 24'h111111) begin
            n_fail++;
            $display("FAIL abort_contents: got err=%b data=%h, want 0 111111", e, dat);
        end
    endtask

    task automatic test_hold_through_done();
        int lat, sc, nrdy; logic e, ee; logic [23:0] dat, erd; bit bok;
        model_txn(0, 1'b0, 1'b1, 8'h30, 24'h2468AC, ee, erd);
        run_txn(0, 1'b0, 1'b1, 8'h30, 24'h2468AC, 1'b1, lat, e, dat, bok, sc);
        n_checks++;
        if (busy_w[0] !== 1'b0 || lat !== 4) begin
            n_fail++;
            $display("FAIL hold_idle: got busy=%b lat=%0d, want busy=0 lat=4", busy_w[0], lat);
        end
        nrdy = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge Clock); #1;
            if (rdy_w[0] === 1'b1 || busy_w[0] === 1'b1) nrdy++;
        end
        n_checks++;
        if (nrdy !== 0) begin
            n_fail++;
            $display("FAIL hold_single: got %0d extra active cycles want 0", nrdy);
        end
    endtask

    task automatic test_random();
        int lat, sc, d, kind; logic e, ee, rd, wr; logic [7:0] a; logic [23:0] wd, dat, erd; bit bok;
        for (int i = 0; i < 60; i++) begin
            d    = int'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 9));
            a    = 8'($urandom_range(0, 255));
            wd   = 24'($urandom);
            rd   = (kind == 0) || (kind >= 5);
            wr   = (kind <= 4);
            if (rd && !wr && int'(a) < DEPTHS[d] && !mval[d][a]) begin
                rd = 1'b0; wr = 1'b1;
            end
            model_txn(d, rd, wr, a, wd, ee, erd);
            run_txn(d, rd, wr, a, wd, 1'b0, lat, e, dat, bok, sc);
            n_checks++;
            if (lat !== WC[d] + 2 || e !== ee || dat !== erd || !bok) begin
                n_fail++;
                $display("FAIL rand%0d dut%0d rd=%b wr=%b a=%h: got lat=%0d err=%b data=%h busy_ok=%b, want %0d %b %h 1",
                         i, d, rd, wr, a, lat, e, dat, bok, WC[d] + 2, ee, erd);
            end
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        Reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            mr[d] = 1'b0; mw[d] = 1'b0; ad[d] = 8'h0; wdv[d] = 24'h0; mrd[d] = 24'h0;
            for (int j = 0; j < 256; j++) begin
                mval[d][j] = 1'b0; mmem[d][j] = 24'h0;
            end
        end
        test_reset();
        test_basic();
        test_zero_wait();
        test_error_both();
        test_depth();
        test_reset_abort();
        test_hold_through_done();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
